// File: rtl/seqadd_if.sv
// Handshake and operand/result bundle for the multi-cycle sequential adder.
// The master side requests additions and the slave side (the adder) returns results.
interface seqadd_if #(
   parameter int WIDTH = 64
) ();
   logic             start;
   logic             flush;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;

   modport master (
      output start, flush, a, b, carry_in,
      input  busy, done, sum, carry_out
   );

   modport slave (
      input  start, flush, a, b, carry_in,
      output busy, done, sum, carry_out
   );
endinterface

// File: rtl/seqadd_ctrl.sv
// Wide adder built from one CHUNK-bit slice and a registered carry. It consumes
// one slice per cycle, low chunk first, and shifts the result in from the top.
module seqadd_ctrl #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic   clk,
   input  logic   reset,
   seqadd_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 2) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] op_a_reg, op_a_next;
   logic [WIDTH-1:0] op_b_reg, op_b_next;
   logic             carry_reg, carry_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic             cout_reg, cout_next;
   logic [CHUNK:0]   slice;
   logic             accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         op_a_reg  <= '0;
         op_b_reg  <= '0;
         carry_reg <= 1'b0;
         count_reg <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         op_a_reg  <= op_a_next;
         op_b_reg  <= op_b_next;
         carry_reg <= carry_next;
         count_reg <= count_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      op_a_next  = op_a_reg;
      op_b_next  = op_b_reg;
      carry_next = carry_reg;
      count_next = count_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;
      slice      = {1'b0, op_a_reg[CHUNK-1:0]} + {1'b0, op_b_reg[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry_reg};
      accept     = bus.start && !bus.flush && (state_reg != ADD);

      if (bus.flush) begin
         // Cancel wins over everything; partial Sum/CarryOut are left untouched.
         state_next = IDLE;
         count_next = '0;
      end else begin
         case (state_reg)
            ADD: begin
               sum_next   = {slice[CHUNK-1:0], sum_reg[WIDTH-1:CHUNK]};
               op_a_next  = op_a_reg >> CHUNK;
               op_b_next  = op_b_reg >> CHUNK;
               carry_next = slice[CHUNK];
               count_next = count_reg + 1'b1;
               if (count_reg == CW'(NCHUNK - 1)) begin
                  cout_next  = slice[CHUNK];
                  state_next = DONE;
               end
            end
            IDLE, DONE: begin
               if (accept) begin
                  op_a_next  = bus.a;
                  op_b_next  = bus.b;
                  carry_next = bus.carry_in;
                  count_next = '0;
                  state_next = ADD;
               end else begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign bus.busy      = (state_reg == ADD);
   assign bus.done      = (state_reg == DONE);
   assign bus.sum       = sum_reg;
   assign bus.carry_out = cout_reg;
endmodule

// File: tb/tb_seqadd_ctrl.sv
// Randomized and directed bench for seqadd_ctrl against a cycle-level arithmetic model.
module tb_seqadd_ctrl;
   localparam int W = 64;
   localparam int C = 16;
   localparam int N = W / C;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   seqadd_if #(.WIDTH(W)) bus ();
   seqadd_ctrl #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;
   int busy_cnt = 0;
   int done_cnt = 0;

   // Model: an accepted op yields res = A+B+Cin; after j busy edges, the top
   // j chunks of Sum hold the low j chunks of res and the rest is old Sum shifted.
   logic [W:0]   m_res;
   logic [W-1:0] m_old;
   logic [W-1:0] m_sum;
   logic         m_cout;
   int           m_left;
   int           m_j;
   logic         m_done;

   task automatic cmp(input string name, input logic [W:0] act, input logic [W:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_res <= '0; m_old <= '0; m_sum <= '0; m_cout <= 1'b0;
         m_left <= 0; m_j <= 0; m_done <= 1'b0;
      end else if (bus.flush) begin
         m_left <= 0;
         m_done <= 1'b0;
      end else if (m_left == 0 && bus.start) begin
         m_res  <= {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.carry_in};
         m_old  <= m_sum;
         m_j    <= 0;
         m_left <= N;
         m_done <= 1'b0;
      end else if (m_left > 0) begin
         automatic int jn = m_j + 1;
         m_sum  <= (m_old >> (C * jn)) | (m_res[W-1:0] << (W - C * jn));
         m_j    <= jn;
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done <= 1'b1;
            m_cout <= m_res[W];
         end
      end else begin
         m_done <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         cmp("busy", {64'd0, bus.busy}, {64'd0, m_left > 0});
         cmp("done", {64'd0, bus.done}, {64'd0, m_done});
         cmp("sum", {1'b0, bus.sum}, {1'b0, m_sum});
         cmp("carry_out", {64'd0, bus.carry_out}, {64'd0, m_cout});
         if (bus.busy) busy_cnt++;
         if (bus.done) done_cnt++;
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.carry_in = ci;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Returns at negedge+1 of the Done cycle, or reports a timeout.
   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #1;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL %s timeout: done never rose within 20 cycles", tag);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      int b0, d0;
      bus.start = 1'b0; bus.flush = 1'b0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0;
      #1;
      cmp("rst_busy", {64'd0, bus.busy}, 65'd0);
      cmp("rst_done", {64'd0, bus.done}, 65'd0);
      cmp("rst_sum", {1'b0, bus.sum}, 65'd0);
      cmp("rst_cout", {64'd0, bus.carry_out}, 65'd0);
      @(negedge clk); #2 reset = 1'b0;
      idle_cycles(2);

      // Full carry ripple
      b0 = busy_cnt; d0 = done_cnt;
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      wait_done("ripple");
      cmp("ripple_sum", {1'b0, bus.sum}, 65'd0);
      cmp("ripple_cout", {64'd0, bus.carry_out}, 65'd1);
      idle_cycles(3);
      cmp("ripple_busy_cycles", 65'(busy_cnt - b0), 65'd4);
      cmp("ripple_done_pulses", 65'(done_cnt - d0), 65'd1);

      // CarryIn path, followed back-to-back by a Start held during Done
      issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
      wait_done("cin");
      cmp("cin_sum", {1'b0, bus.sum}, 65'd1);
      cmp("cin_cout", {64'd0, bus.carry_out}, 65'd1);
      bus.start = 1'b1; bus.a = 64'h1234; bus.b = 64'h1; bus.carry_in = 1'b0;
      @(posedge clk); #1 bus.start = 1'b0;
      cmp("b2b_busy_next", {64'd0, bus.busy}, 65'd1);
      wait_done("b2b");
      cmp("b2b_sum", {1'b0, bus.sum}, 65'h1235);
      cmp("b2b_cout", {64'd0, bus.carry_out}, 65'd0);

      // Start while busy is ignored
      idle_cycles(2);
      d0 = done_cnt;
      issue(64'd100, 64'd23, 1'b0);
      @(posedge clk); #1 bus.start = 1'b1; bus.a = 64'd999; bus.b = 64'd1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done("busy_start");
      cmp("busy_start_sum", {1'b0, bus.sum}, 65'd123);
      idle_cycles(8);
      cmp("busy_start_pulses", 65'(done_cnt - d0), 65'd1);

      // Flush mid-op, with a simultaneous Start that must lose
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      @(posedge clk); #1 bus.flush = 1'b1; bus.start = 1'b1; bus.a = 64'd3; bus.b = 64'd3;
      @(posedge clk); #1 bus.flush = 1'b0; bus.start = 1'b0;
      d0 = done_cnt;
      @(negedge clk);
      cmp("flush_busy", {64'd0, bus.busy}, 65'd0);
      idle_cycles(8);
      cmp("flush_no_done", 65'(done_cnt - d0), 65'd0);
      issue(64'd5, 64'd7, 1'b0);
      wait_done("after_flush");
      cmp("after_flush_sum", {1'b0, bus.sum}, 65'd12);
      cmp("after_flush_cout", {64'd0, bus.carry_out}, 65'd0);

      // Asynchronous reset mid-op
      idle_cycles(2);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      @(posedge clk); #1;
      @(negedge clk); #2 reset = 1'b1;
      #1;
      cmp("arst_busy", {64'd0, bus.busy}, 65'd0);
      cmp("arst_done", {64'd0, bus.done}, 65'd0);
      cmp("arst_sum", {1'b0, bus.sum}, 65'd0);
      cmp("arst_cout", {64'd0, bus.carry_out}, 65'd0);
      @(negedge clk); #2 reset = 1'b0;
      d0 = done_cnt;
      idle_cycles(8);
      cmp("arst_no_done", 65'(done_cnt - d0), 65'd0);

      // Random traffic; the per-cycle compare process does the checking
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         bus.start    = ($urandom % 3) == 0;
         bus.flush    = ($urandom % 12) == 0;
         bus.a        = {$urandom, $urandom};
         bus.b        = (($urandom % 4) == 0) ? ~bus.a : {$urandom, $urandom};
         bus.carry_in = $urandom % 2;
      end
      @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
      idle_cycles(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seqadd_ctrl.md
# seqadd_ctrl

Sequencing controller that computes a WIDTH-bit sum over multiple cycles by driving a single CHUNK-bit adder slice with a registered carry. It sits beside area-constrained datapaths that need occasional wide additions, such as multi-precision counters or address accumulation, where a full-width single-cycle adder is not justified. Control is a start/busy/done handshake with a synchronous flush.

## Interface
- WIDTH, 64: operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 16: adder slice width; NCHUNK = WIDTH/CHUNK must be at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  request a new addition; sampled only when Busy=0.
- Flush  in  1  synchronous cancel of any in-flight operation.
- A  in  WIDTH  addend, captured on Start acceptance.
- B  in  WIDTH  addend, captured on Start acceptance.
- CarryIn  in  1  carry into bit 0, captured on Start acceptance.
- Busy  out  1  an operation is in progress (state ADD).
- Done  out  1  one-cycle pulse: Sum and CarryOut are final.
- Sum  out  WIDTH  result register.
- CarryOut  out  1  carry out of bit WIDTH-1.

## Operation
- States are IDLE, ADD and DONE. Busy=1 only in ADD. Done=1 only in DONE.
- Start is accepted on an edge when the state is IDLE or DONE, Start=1 and Flush=0. On acceptance:
  - opA <= A, opB <= B, carry <= CarryIn, Count <= 0, state <= ADD.
- On each ADD edge:
  - {c, s} = opA[CHUNK-1:0] + opB[CHUNK-1:0] + carry.
  - Sum <= {s, Sum[WIDTH-1:CHUNK]}, so Sum is a right-shift register that fills from the top.
  - opA and opB shift right by CHUNK.
  - carry <= c.
  - Count <= Count+1.
- On the ADD edge where Count == NCHUNK-1: CarryOut <= c and state <= DONE.
- In DONE, Done=1 for exactly one cycle. The next edge goes to ADD if a Start is accepted, otherwise to IDLE.
- Sum and CarryOut hold their values in IDLE and DONE until the next ADD edge modifies them.
- Arithmetic is modulo 2^WIDTH; the overflow carry appears only on CarryOut.
- Start with Busy=1 is ignored and has no effect on operands or result.
- Flush=1 on any edge forces state <= IDLE and Count <= 0.
  - An in-flight Start is dropped and Done does not pulse for the cancelled operation.
  - Sum and CarryOut keep their current (partial) contents.
- Flush and Start asserted in the same cycle: Flush wins.
- Asynchronous reset, including mid-operation, immediately sets:
  - state=IDLE, Busy=0, Done=0, Sum=0, CarryOut=0;
  - opA=0, opB=0, carry=0, Count=0.

## Timing
- Start accepted at edge k: Busy=1 from edge k through edge k+NCHUNK. Done=1 in the cycle after edge k+NCHUNK.
- Latency from the Start-sampling edge to Done high is NCHUNK cycles; this is 4 for the defaults.
- Back-to-back throughput: a Start held during the Done cycle is accepted with zero idle cycles, giving one result per NCHUNK+1 cycles.
- Busy drops in the same cycle that Done rises.
- After Flush, the earliest new Start is accepted on the following edge.
- The critical path is one CHUNK-bit add plus the carry register; there is no combinational path from inputs to outputs.

## Test plan
- Full carry ripple: WIDTH=64, CHUNK=16, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, CarryIn=0, Start for 1 cycle -> Busy for 4 cycles, Done pulses once, Sum=0, CarryOut=1.
- CarryIn path: A=B=0x8000_0000_0000_0000, CarryIn=1 -> Sum=0x1, CarryOut=1.
- Back-to-back: assert Start with A=0x1234, B=0x1 during the Done cycle of a previous op -> Busy=1 the next cycle, Done 4 cycles later, Sum=0x1235, CarryOut=0.
- Start while busy: a second Start with different operands at ADD cycle 2 -> ignored; the result equals the first operation's sum and exactly one Done pulse occurs.
- Flush mid-op: Flush at ADD cycle 2 -> Busy=0 next cycle and no Done. A following Start with A=5, B=7, CarryIn=0 -> Sum=12, CarryOut=0 (no stale carry).
- Async reset mid-op: assert reset between edges at ADD cycle 3 -> Busy, Done, Sum and CarryOut are 0 before the next clock edge. After release, no Done appears until a new Start.
